// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

   // Access sequencing: accept in IDLE, count wait states, respond for one cycle
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // funct3 encodings for loads/stores
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Wait-state counter width (covers 0..15)
   localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_align.sv
// Byte-lane steering for loads and stores: byte enables, replicated store
// data, load extraction with sign/zero extension, and access legality flags.
module dmem_align
   import dmem_pkg::*;
(
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] mem_word,
   output logic [3:0]  byte_en,
   output logic [31:0] store_data,
   output logic [31:0] load_data,
   output logic        misalign,
   output logic        invalid
);

   logic [31:0] shifted_word;
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   assign shifted_word = mem_word >> {addr_lo, 3'b000};
   assign sel_byte     = shifted_word[7:0];
   assign sel_half     = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];

   // Decode size/sign into lane masks, steered data and legality
   always_comb begin
      byte_en    = 4'b0000;
      store_data = 32'd0;
      load_data  = 32'd0;
      misalign   = 1'b0;
      invalid    = 1'b0;
      case (funct3)
         F3_B, F3_BU: begin
            // unsigned variant only exists for loads
            invalid    = is_store && (funct3 == F3_BU);
            byte_en    = 4'b0001 << addr_lo;
            store_data = {4{wdata[7:0]}};
            load_data  = funct3[2] ? {24'd0, sel_byte}
                                   : {{24{sel_byte[7]}}, sel_byte};
         end
         F3_H, F3_HU: begin
            invalid    = is_store && (funct3 == F3_HU);
            misalign   = addr_lo[0];
            byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
            store_data = {2{wdata[15:0]}};
            load_data  = funct3[2] ? {16'd0, sel_half}
                                   : {{16{sel_half[15]}}, sel_half};
         end
         F3_W: begin
            misalign   = (addr_lo != 2'b00);
            byte_en    = 4'b1111;
            store_data = wdata;
            load_data  = mem_word;
         end
         default: begin
            invalid = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, inserts
// WAIT_CYCLES wait states, then completes with a one-cycle done pulse.
// Illegal accesses complete with err=1 and never touch the array.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        read_en,
   input  logic        write_en,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        done,
   output logic        busy,
   output logic        err
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [AW-1:0]    idx_reg;
   logic [1:0]       lo_reg;
   logic [2:0]       f3_reg;
   logic [31:0]      wdata_reg;
   logic             store_reg;
   logic             err_reg;

   logic [31:0]      mem [DEPTH_WORDS];
   logic [31:0]      mem_q;

   logic             req;
   logic             is_idle;
   logic             accept;
   logic             req_err;
   logic             mem_we;
   logic             mem_re;
   logic [AW-1:0]    idx_in;

   logic             al_store;
   logic [2:0]       al_f3;
   logic [1:0]       al_lo;
   logic [31:0]      al_wdata;
   logic [3:0]       byte_en;
   logic [31:0]      store_data;
   logic [31:0]      load_data;
   logic             misalign;
   logic             invalid;

   logic             unused_addr;

   assign req     = read_en | write_en;
   assign is_idle = (state_reg == ST_IDLE);
   assign accept  = is_idle & req;
   assign idx_in  = addr[AW+1:2];
   assign unused_addr = &{1'b0, addr[31:AW+2]};

   // In IDLE the aligner checks the live request; afterwards it works on the latched copy
   assign al_store = is_idle ? write_en    : store_reg;
   assign al_f3    = is_idle ? funct3      : f3_reg;
   assign al_lo    = is_idle ? addr[1:0]   : lo_reg;
   assign al_wdata = is_idle ? wdata       : wdata_reg;

   dmem_align u_align (
      .is_store   (al_store),
      .funct3     (al_f3),
      .addr_lo    (al_lo),
      .wdata      (al_wdata),
      .mem_word   (mem_q),
      .byte_en    (byte_en),
      .store_data (store_data),
      .load_data  (load_data),
      .misalign   (misalign),
      .invalid    (invalid)
   );

   // Both enables high is handled as a store that is always rejected
   assign req_err = (read_en & write_en) | invalid | misalign;
   assign mem_re  = accept & ~write_en & ~req_err;
   assign mem_we  = (state_reg == ST_RESP) & store_reg & ~err_reg;

   // Access sequencer: latch request, count wait states, respond once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         idx_reg   <= '0;
         lo_reg    <= '0;
         f3_reg    <= '0;
         wdata_reg <= '0;
         store_reg <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (req) begin
                  idx_reg   <= idx_in;
                  lo_reg    <= addr[1:0];
                  f3_reg    <= funct3;
                  wdata_reg <= wdata;
                  store_reg <= write_en;
                  err_reg   <= req_err;
                  cnt_reg   <= WAIT_INIT;
                  state_reg <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
               end
            end
            ST_WAIT: begin
               cnt_reg <= cnt_reg - 1'b1;
               if (cnt_reg == 1) begin
                  state_reg <= ST_RESP;
               end
            end
            ST_RESP: begin
               state_reg <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   // Registered array read, issued at acceptance from the held request address
   always_ff @(posedge clk) begin
      if (mem_re) begin
         mem_q <= mem[idx_in];
      end
   end

   // Store commits on the RESP edge, only the addressed lanes
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
               mem[idx_reg][8*i +: 8] <= store_data[8*i +: 8];
            end
         end
      end
   end

   assign done  = (state_reg == ST_RESP);
   assign err   = done & err_reg;
   assign rdata = (done & ~store_reg & ~err_reg) ? load_data : 32'd0;
   assign busy  = rst_n & ((state_reg == ST_WAIT) | accept);

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder on the far side of the decoder's `read_en`/`write_en` load/store strobes. It accepts one access at a time and completes it after a parameterised number of wait states, stalling the pipeline while the access is in progress. Loads of byte, half and word size return sign- or zero-extended data; stores of the same sizes write only the addressed byte lanes. Misaligned and invalid accesses are reported and never touch the memory array.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words in the array; power of two, ≥ 4.
- `WAIT_CYCLES`, 2: wait states inserted between acceptance and response; 0–15.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `read_en` in 1: load request from the decode/execute stage.
- `write_en` in 1: store request.
- `funct3` in 3: access size and sign from the instruction.
- `addr` in 32: byte address (ALU result).
- `wdata` in 32: store data, right-aligned.
- `rdata` out 32: load result, extended to 32 bits; valid while `done`=1.
- `done` out 1: one-cycle completion pulse.
- `busy` out 1: stall request; the pipeline holds the request stable while this is 1.
- `err` out 1: access was misaligned, used an invalid `funct3`, or had both enables high; valid with `done`.

## Operation
- Request: `req` = `read_en` | `write_en`.
- The FSM has three states: IDLE, WAIT and RESP.
- IDLE, `req`=1 at a rising edge:
  - latch `addr`, `funct3`, `wdata`, op and the error check;
  - load the counter with `WAIT_CYCLES`;
  - go to WAIT, or go directly to RESP when `WAIT_CYCLES`=0.
- WAIT:
  - decrement the counter each cycle;
  - when the counter is 1, go to RESP.
  - `req` is ignored in WAIT.
- RESP:
  - `done`=1;
  - the write commits and `rdata` is driven in this cycle;
  - unconditionally return to IDLE;
  - `req` is ignored in RESP.
- `busy` = (state==WAIT) | (state==IDLE & `req`). It is forced to 0 while `rst_n`=0. It is 0 in RESP so the pipeline advances.
- Load decode (`read_en`):
  - 000 LB and 100 LBU select byte `addr[1:0]`;
  - 001 LH and 101 LHU select half `addr[1]`;
  - 010 LW selects the whole word;
  - LB and LH sign-extend; LBU and LHU zero-extend.
- Store decode (`write_en`):
  - 000 SB writes one lane;
  - 001 SH writes two lanes;
  - 010 SW writes all four lanes;
  - the store data is `wdata` low bits replicated into the addressed lanes.
- Error conditions, checked in this order:
  1. both enables high → treat as a store, `err`=1, no write;
  2. invalid `funct3` for the op → `err`=1;
  3. misalignment → `err`=1 (half access with `addr[0]`=1; word access with `addr[1:0]`≠0).
- On any error: no array access, `rdata`=0, and `done` still pulses.
- Word index is `addr[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap modulo the array size.
- The array is not reset; its contents survive `rst_n`.

## Timing
- Reset values: state=IDLE, counter=0, `rdata`=0, `done`=0, `err`=0, `busy`=0.
- Request presented in cycle 0:
  - `busy`=1 in cycles 0..`WAIT_CYCLES`;
  - `done`/`rdata`/`err` appear in cycle `WAIT_CYCLES`+1;
  - the store becomes visible to a load accepted in any later cycle.
- Back-to-back accesses: the earliest next acceptance is the cycle after RESP. Throughput is one access per `WAIT_CYCLES`+2 cycles.
- `rdata`, `done` and `err` are registered outputs and return to 0 the cycle after RESP.
- Reset mid-access (in WAIT or RESP): the FSM returns to IDLE immediately and the pending store is discarded. If reset is asserted before the RESP edge, the array is unmodified.
- A request that drops in WAIT is not a protocol violation: the latched copy completes.

## Structure
- `dmem_pkg` holds:
  - the state enum;
  - localparams for `funct3` codes `F3_B`/`F3_H`/`F3_W`/`F3_BU`/`F3_HU`;
  - the counter width.
- Sub-module `dmem_align` is combinational. Inputs: `funct3` and `addr[1:0]`. Outputs: byte-enable mask, store lane data, load extract/extend, and the misalign/invalid flags. The top level holds the FSM, counter and array.

## Test plan
- LW: `WAIT_CYCLES`=2, memory word 0x10 = 0x8765_4321, LW `addr`=0x10.
  - `busy` is high in cycles 0–2;
  - cycle 3 has `done`=1 and `rdata`=0x8765_4321.
- Store then loads: SB 0xAB to 0x13 after memory word 0x10 = 0.
  - LB 0x13 → 0xFFFF_FFAB;
  - LBU 0x13 → 0x0000_00AB;
  - LW 0x10 → 0xAB00_0000.
- Misaligned: LH at 0x11 → `done`=1, `err`=1, `rdata`=0. SW at 0x12 → `err`=1 and memory is unchanged.
- Both enables high: `read_en`=`write_en`=1 → `err`=1, no write.
- Wrap and zero wait: `WAIT_CYCLES`=0, `DEPTH_WORDS`=1024, SW 0x1234 to 0x1000, LW 0x0000.
  - the load returns 0x1234 (address wraps);
  - `done` arrives in cycle 1.
- Reset mid-access: `rst_n` pulsed low during WAIT of SW 0xFFFF_FFFF to 0x20.
  - `busy`=0 and `done`=0 immediately;
  - a later LW 0x20 returns the old value.
